regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side front end for the CPU's 32x32 register file.
- Accepts destination-register results from two producers, the ALU and the memory/load unit, over valid/ready handshakes.
- Buffers accepted results in a small in-order FIFO and drains one per cycle onto the register file write port (regW/Wdat/RegWrite).
- Exports per-read-port hazard flags so decode can stall while a read register still has a write in flight.

Parameters:
DEPTH, 4, FIFO entries; power of 2, ≥2
DW, 32, data width
AW, 5, register address width

Ports:
clk  input  1  clock, rising edge
Rst  input  1  reset, synchronous, active-high
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle when valid&ready
alu_reg  input  AW  ALU destination register
alu_data  input  DW  ALU result
mem_valid  input  1  load result offered
mem_ready  output  1  load result accepted this cycle when valid&ready
mem_reg  input  AW  load destination register
mem_data  input  DW  load result
regW  output  AW  register file write address
Wdat  output  DW  register file write data
RegWrite  output  1  register file write strobe, one cycle per write
regA  input  AW  read-port A query register
regB  input  AW  read-port B query register
regC  input  AW  read-port C query register
hazA  output  1  write to regA pending
hazB  output  1  write to regB pending
hazC  output  1  write to regC pending
count  output  log2(DEPTH)+1  FIFO occupancy
empty  output  1  FIFO empty and no write in output stage

Behaviour:
- Reset, synchronous on the clk edge with Rst=1:
  - FIFO pointers and count go to 0; all entries are invalidated.
  - regW=0, Wdat=0, RegWrite=0, and hazA/hazB/hazC evaluate to 0.
  - Rst mid-operation discards every queued and in-flight write; no RegWrite pulses follow.
- Readiness is computed from registered count, never from same-cycle pop:
  - mem_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH) && !mem_valid.
  - At most one push per cycle. mem has fixed priority; ALU is starved while mem_valid holds.
- Push:
  - A handshake (valid&ready) at edge k writes {reg, data} to the FIFO tail. count increments unless a pop occurs the same edge.
  - Destination register 0 is accepted (ready behaves normally) but not enqueued; count is unchanged and no RegWrite pulse is produced.
- Pop:
  - At each edge with count>0, the head is moved to regW/Wdat, RegWrite=1 for the following cycle, and count decrements.
  - With count==0, RegWrite=0 and regW/Wdat hold their previous values.
  - Push and pop in the same edge: count unchanged.
  - Full FIFO: pop proceeds, push is refused that cycle.
- Latency: a result accepted at edge k with an empty FIFO drives RegWrite during cycle k+1..k+2. Back-to-back accepts produce back-to-back RegWrite pulses in acceptance order.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; no overflow or underflow is possible by construction.
- Hazards (combinational):
  - hazX=1 if regX≠0 and regX matches any valid FIFO entry or (RegWrite && regW==regX).
  - Producer inputs in the same cycle, before acceptance, are not considered.
  - hazX is always 0 for register 0.
- empty = (count==0) && !RegWrite.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined:
  - Adds outputs fwdA, fwdB, fwdC (DW) and fwd_hitA, fwd_hitB, fwd_hitC (1).
  - On a hazard, fwd_hitX=1 and fwdX carries the data of the youngest matching pending write; the FIFO tail-most entry beats older entries and the output stage.
  - With no hit, fwd_hitX=0 and fwdX=0.
- Undefined: those ports are absent; hazard flags only; all other behaviour is identical.

Test Plan:
- Reset then single ALU push reg 5 data 0xDEADBEEF at edge 1 -> RegWrite=1, regW=5, Wdat=0xDEADBEEF in cycle 2 only; hazA=1 with regA=5 from after edge 1 until RegWrite drops.
- alu_valid and mem_valid both high, mem reg 3 = 0x11, alu reg 4 = 0x22 -> mem accepted first, alu_ready=0 that cycle; writes appear reg3 then reg4 on consecutive cycles.
- Push 5 results with pop side kept busy, DEPTH=4 and pushes every cycle -> count never exceeds 4; ready drops only when count==4; all 5 written in order, none lost.
- Push to reg 0 with data 0xFFFFFFFF -> accepted, count stays 0, no RegWrite, hazA=0 with regA=0.
- Queue 3 writes, assert Rst for one edge -> count=0, RegWrite=0 next cycle, no further writes, all haz flags 0.
- With WB_FORWARD_EN: queue reg 7 = 0x1 then reg 7 = 0x2, regB=7 -> fwd_hitB=1, fwdB=0x2 until the second write drains.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back front end for the 32x32 register file: merges ALU and load results
// into an in-order FIFO, drains one per cycle, and flags pending-write hazards.
// Optional WB_FORWARD_EN adds per-read-port forwarding data of the youngest pending write.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_reg,
  input  logic [DW-1:0]              alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_reg,
  input  logic [DW-1:0]              mem_data,
  output logic [AW-1:0]              regW,
  output logic [DW-1:0]              Wdat,
  output logic                       RegWrite,
  input  logic [AW-1:0]              regA,
  input  logic [AW-1:0]              regB,
  input  logic [AW-1:0]              regC,
  output logic                       hazA,
  output logic                       hazB,
  output logic                       hazC,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
`ifdef WB_FORWARD_EN
  ,
  output logic [DW-1:0]              fwdA,
  output logic [DW-1:0]              fwdB,
  output logic [DW-1:0]              fwdC,
  output logic                       fwd_hitA,
  output logic                       fwd_hitB,
  output logic                       fwd_hitC
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    entReg [DEPTH];
  logic [DW-1:0]    entDat [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wrPtr, rdPtr;

  logic             notFull, accept, push, pop;
  logic [AW-1:0]    pushReg;
  logic [DW-1:0]    pushDat;

  // Readiness uses only the registered count, so a same-edge pop never frees a slot early.
  assign notFull   = (count < CW'(DEPTH));
  assign mem_ready = notFull;
  assign alu_ready = notFull && !mem_valid;

  assign pushReg = mem_valid ? mem_reg  : alu_reg;
  assign pushDat = mem_valid ? mem_data : alu_data;
  assign accept  = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push    = accept && (pushReg != '0);
  assign pop     = (count != '0);

  assign empty = (count == '0) && !RegWrite;

  always_ff @(posedge clk) begin
    if (Rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      vld      <= '0;
      regW     <= '0;
      Wdat     <= '0;
      RegWrite <= 1'b0;
    end else begin
      if (pop) begin
        regW       <= entReg[rdPtr];
        Wdat       <= entDat[rdPtr];
        vld[rdPtr] <= 1'b0;
        rdPtr      <= rdPtr + PW'(1);
        RegWrite   <= 1'b1;
      end else begin
        RegWrite   <= 1'b0;
      end
      if (push) begin
        vld[wrPtr] <= 1'b1;
        wrPtr      <= wrPtr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entReg[wrPtr] <= pushReg;
      entDat[wrPtr] <= pushDat;
    end
  end

  logic [AW-1:0] qry [3];
  logic [2:0]    haz;
  assign qry[0] = regA;
  assign qry[1] = regB;
  assign qry[2] = regC;

`ifdef WB_FORWARD_EN
  logic [DW-1:0] fwdDat [3];
`endif

  // Entries are scanned oldest to youngest from the head, so the last match is the youngest.
  always_comb begin : hazScan
    logic [PW-1:0] idx;
    haz = '0;
    idx = '0;
`ifdef WB_FORWARD_EN
    for (int unsigned p = 0; p < 3; p++) fwdDat[p] = '0;
`endif
    for (int unsigned p = 0; p < 3; p++) begin
      if (qry[p] != '0) begin
        if (RegWrite && (regW == qry[p])) begin
          haz[p] = 1'b1;
`ifdef WB_FORWARD_EN
          fwdDat[p] = Wdat;
`endif
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          idx = rdPtr + PW'(k);
          if (vld[idx] && (entReg[idx] == qry[p])) begin
            haz[p] = 1'b1;
`ifdef WB_FORWARD_EN
            fwdDat[p] = entDat[idx];
`endif
          end
        end
      end
    end
  end

  assign hazA = haz[0];
  assign hazB = haz[1];
  assign hazC = haz[2];

`ifdef WB_FORWARD_EN
  assign fwd_hitA = haz[0];
  assign fwd_hitB = haz[1];
  assign fwd_hitC = haz[2];
  assign fwdA     = fwdDat[0];
  assign fwdB     = fwdDat[1];
  assign fwdC     = fwdDat[2];
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic, all checked
// against a queue-based model of pending writes and the output stage.
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          Rst;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_reg, mem_reg, regA, regB, regC, regW;
  logic [DW-1:0] alu_data, mem_data, Wdat;
  logic          RegWrite, hazA, hazB, hazC, empty;
  logic [2:0]    count;
`ifdef WB_FORWARD_EN
  logic [DW-1:0] fwdA, fwdB, fwdC;
  logic          fwd_hitA, fwd_hitB, fwd_hitC;
`endif

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .Rst(Rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .regW(regW), .Wdat(Wdat), .RegWrite(RegWrite),
    .regA(regA), .regB(regB), .regC(regC),
    .hazA(hazA), .hazB(hazB), .hazC(hazC),
    .count(count), .empty(empty)
`ifdef WB_FORWARD_EN
    , .fwdA(fwdA), .fwdB(fwdB), .fwdC(fwdC),
    .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB), .fwd_hitC(fwd_hitC)
`endif
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending writes in acceptance order plus the output stage.
  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  bit            outV;
  logic [AW-1:0] outR;
  logic [DW-1:0] outD;

  function automatic bit mHaz(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    if (outV && outR == r) return 1'b1;
    foreach (q[i]) if (q[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] mFwd(input logic [AW-1:0] r);
    if (r == 0) return '0;
    for (int i = int'(q.size()) - 1; i >= 0; i--) if (q[i].r == r) return q[i].d;
    if (outV && outR == r) return outD;
    return '0;
  endfunction

  task automatic cycle(input bit rst,
                       input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                       input logic [AW-1:0] qa, input logic [AW-1:0] qb, input logic [AW-1:0] qc);
    bit   spaceOk, memAcc, aluAcc;
    ent_t e;
    Rst = rst; alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    regA = qa; regB = qb; regC = qc;
    #1;
    spaceOk = (q.size() < DEPTH);
    checkVal("mem_ready", mem_ready, spaceOk);
    checkVal("alu_ready", alu_ready, spaceOk && !mv);
    checkVal("count", count, q.size());
    checkVal("empty", empty, (q.size() == 0) && !outV);
    checkVal("RegWrite", RegWrite, outV);
    checkVal("regW", regW, outR);
    checkVal("Wdat", Wdat, outD);
    checkVal("hazA", hazA, mHaz(qa));
    checkVal("hazB", hazB, mHaz(qb));
    checkVal("hazC", hazC, mHaz(qc));
`ifdef WB_FORWARD_EN
    checkVal("fwd_hitA", fwd_hitA, mHaz(qa));
    checkVal("fwd_hitB", fwd_hitB, mHaz(qb));
    checkVal("fwd_hitC", fwd_hitC, mHaz(qc));
    checkVal("fwdA", fwdA, mFwd(qa));
    checkVal("fwdB", fwdB, mFwd(qb));
    checkVal("fwdC", fwdC, mFwd(qc));
`endif
    memAcc = mv && spaceOk;
    aluAcc = av && !mv && spaceOk;
    @(posedge clk);
    if (rst) begin
      q.delete();
      outV = 0; outR = '0; outD = '0;
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        outV = 1; outR = e.r; outD = e.d;
      end else begin
        outV = 0;
      end
      if (memAcc && mr != 0) q.push_back('{r: mr, d: md});
      else if (aluAcc && ar != 0) q.push_back('{r: ar, d: ad});
    end
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] qa, input logic [AW-1:0] qb, input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, '0, qa, qb, 5'd0);
  endtask

  initial begin
    outV = 0; outR = '0; outD = '0;
    Rst = 1; alu_valid = 0; mem_valid = 0; alu_reg = '0; mem_reg = '0;
    alu_data = '0; mem_data = '0; regA = '0; regB = '0; regC = '0;
    @(posedge clk); #1;
    cycle(1, 0, '0, '0, 0, '0, '0, 5'd5, 5'd0, 5'd0);

    // Single ALU push, hazard on regA until the write leaves the output stage.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 5'd5, 5'd0, 5'd0);
    idle(5'd5, 5'd0, 3);

    // Simultaneous offers: load wins, ALU keeps offering until accepted.
    cycle(0, 1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 5'd3, 5'd4, 5'd0);
    cycle(0, 1, 5'd4, 32'h22, 0, '0, '0, 5'd3, 5'd4, 5'd0);
    idle(5'd3, 5'd4, 3);

    // Five back-to-back pushes.
    for (int i = 0; i < 5; i++)
      cycle(0, (i % 2) == 0, 5'(10 + i), 32'(100 + i), (i % 2) == 1, 5'(10 + i), 32'(200 + i),
            5'(10 + i), 5'd11, 5'd14);
    idle(5'd12, 5'd14, 3);

    // Register 0 is accepted but never written.
    cycle(0, 1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0, 2);

    // Reset in the middle of traffic drops everything.
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 1, 5'(20 + i), 32'(300 + i), 5'd21, 5'd22, 5'd20);
    cycle(1, 0, '0, '0, 1, 5'd23, 32'h5, 5'd21, 5'd22, 5'd23);
    idle(5'd22, 5'd23, 3);

    // Same register written twice: the younger value must win.
    cycle(0, 1, 5'd7, 32'h1, 0, '0, '0, 5'd0, 5'd7, 5'd0);
    cycle(0, 1, 5'd7, 32'h2, 0, '0, '0, 5'd0, 5'd7, 5'd0);
    idle(5'd0, 5'd7, 3);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    idle(5'd1, 5'd2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
